// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, ALU one-hot codes,
// PC source selects and FSM state encoding.
package mips_ctrl_pkg;

  localparam logic [5:0] ROP      = 6'h00;
  localparam logic [5:0] J        = 6'h02;
  localparam logic [5:0] JAL      = 6'h03;
  localparam logic [5:0] BEQ      = 6'h04;
  localparam logic [5:0] BNE      = 6'h05;
  localparam logic [5:0] ADDI     = 6'h08;
  localparam logic [5:0] ANDI     = 6'h0c;
  localparam logic [5:0] ORI      = 6'h0d;
  localparam logic [5:0] LUI      = 6'h0f;
  localparam logic [5:0] POUT     = 6'h1e;
  localparam logic [5:0] PIN      = 6'h1f;
  localparam logic [5:0] LW       = 6'h23;
  localparam logic [5:0] SW       = 6'h2b;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  localparam logic [5:0] ALU_ZER   = 6'd0;
  localparam logic [5:0] ALU_SUB   = 6'd1;
  localparam logic [5:0] ALU_SLL   = 6'd2;
  localparam logic [5:0] ALU_ADD   = 6'd4;
  localparam logic [5:0] ALU_AND   = 6'd8;
  localparam logic [5:0] ALU_OR    = 6'd16;
  localparam logic [5:0] ALU_R_TYP = 6'd32;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_RS     = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_BRANCH = 2'd3;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_JUMP   = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

endpackage

// File: rtl/mips_mem_wait_timer.sv
// Counts consecutive wait-stated memory cycles; flags expiry on the cycle that
// would make the MEM_TIMEOUT-th wait, so the FSM traps on the following edge.
module mips_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic ready,
  output logic expired
);

  logic [TO_W-1:0] r_count;

  // Waiting phases are only left on ready, so clearing when idle covers state changes.
  always_ff @(posedge clk) begin
    if (reset || !active || ready) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + TO_W'(1);
    end
  end

  assign expired = active && !ready && (r_count == TO_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM with wait-stated memory, timeout trap and
// illegal-opcode trap. Optional counters enabled by MIPS_CTRL_PERF_CNT_EN.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [5:0] alu_op,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       jal,
  output logic       pin_en,
  output logic       io_write,
  output logic       trap,
`ifdef MIPS_CTRL_PERF_CNT_EN
  output logic [31:0] instr_count,
  output logic [31:0] stall_count,
`endif
  output logic [2:0] state
);

  state_t r_state;
  state_t w_next;
  logic   w_active;
  logic   w_expired;
  logic   w_is_jr;

  assign w_active = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_is_jr  = (opcode == ROP) && (funct == FUNCT_JR);
  assign state    = reset ? S_FETCH : r_state;

  mips_mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .active  (w_active),
    .ready   (mem_ready),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_PLUS4;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = ALU_ZER;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    jal        = 1'b0;
    pin_en     = 1'b0;
    io_write   = 1'b0;
    trap       = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        alu_op    = ALU_ADD;
        if (w_expired) begin
          w_next = S_TRAP;
        end else if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALU precomputes PC + (imm<<2) so BRANCH can use ALUOut directly.
        alu_src_b = 2'd3;
        alu_op    = ALU_ADD;
        case (opcode)
          ROP:                                w_next = w_is_jr ? S_JUMP : S_EXEC;
          LW, SW, ADDI, ORI, ANDI, LUI, POUT: w_next = S_EXEC;
          BEQ, BNE:                           w_next = S_BRANCH;
          J, JAL:                             w_next = S_JUMP;
          PIN:                                w_next = S_WB;
          default:                            w_next = S_TRAP;
        endcase
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        if (opcode == ROP) begin
          alu_op = ALU_R_TYP;
        end else begin
          alu_src_b = 2'd2;
          case (opcode)
            ORI:     alu_op = ALU_OR;
            ANDI:    alu_op = ALU_AND;
            LUI:     alu_op = ALU_SLL;
            default: alu_op = ALU_ADD;
          endcase
        end
        if (opcode == LW || opcode == SW) begin
          w_next = S_MEM;
        end else if (opcode == POUT) begin
          io_write = 1'b1;
          w_next   = S_FETCH;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        i_or_d    = 1'b1;
        mem_read  = (opcode == LW);
        mem_write = (opcode == SW);
        if (w_expired)      w_next = S_TRAP;
        else if (mem_ready) w_next = (opcode == LW) ? S_WB : S_FETCH;
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (opcode == ROP);
        mem_to_reg = (opcode == LW);
        pin_en     = (opcode == PIN);
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PC_BRANCH;
        pc_write  = (opcode == BEQ) ? zero : ~zero;
        w_next    = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_src    = w_is_jr ? PC_RS : PC_JUMP;
        jal       = (opcode == JAL);
        reg_write = (opcode == JAL);
        w_next    = S_FETCH;
      end
      S_TRAP: begin
        trap   = 1'b1;
        w_next = S_TRAP;
      end
      default: w_next = S_TRAP;
    endcase
    // While reset is held only the FETCH read request is visible.
    if (reset) begin
      mem_read   = 1'b1;
      mem_write  = 1'b0;
      i_or_d     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = PC_PLUS4;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      alu_op     = ALU_ZER;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      jal        = 1'b0;
      pin_en     = 1'b0;
      io_write   = 1'b0;
      trap       = 1'b0;
    end
  end

`ifdef MIPS_CTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_count <= '0;
      stall_count <= '0;
    end else begin
      if (r_state == S_FETCH && mem_ready) instr_count <= instr_count + 32'd1;
      if (w_active && !mem_ready)          stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized instruction-stream bench for mips_multicycle_ctrl with a per-instruction
// behavioural model and literal pins for the directed scenarios.
module tb_mips_multicycle_ctrl;

  localparam int MEM_TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_read, mem_write, i_or_d, ir_write, pc_write;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [5:0] alu_op;
  logic       reg_dst, mem_to_reg, reg_write, jal, pin_en, io_write, trap;
  logic [2:0] state;
`ifdef MIPS_CTRL_PERF_CNT_EN
  logic [31:0] instr_count, stall_count;
  int unsigned m_instr = 0;
  int unsigned m_stall = 0;
`endif

  mips_multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
    .i_or_d(i_or_d), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .jal(jal), .pin_en(pin_en), .io_write(io_write), .trap(trap),
`ifdef MIPS_CTRL_PERF_CNT_EN
    .instr_count(instr_count), .stall_count(stall_count),
`endif
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_read, mem_write, i_or_d, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [5:0] alu_op;
    logic       reg_dst, mem_to_reg, reg_write, jal, pin_en, io_write, trap;
    logic [2:0] state;
  } outs_t;

  typedef enum int {C_R, C_LW, C_SW, C_ADDI, C_ORI, C_ANDI, C_LUI, C_POUT,
                    C_BEQ, C_BNE, C_J, C_JAL, C_JR, C_PIN, C_ILL, C_N} cls_t;

  outs_t got, exp_b;
  bit    exp_valid = 1'b0;
  outs_t obs_q[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;

  assign got = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src, alu_src_a,
                alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, jal, pin_en,
                io_write, trap, state};

  // ---------------- behavioural model: what each cycle of an instruction must do
  function automatic logic [5:0] op_of(cls_t c);
    case (c)
      C_R, C_JR: return 6'h00;
      C_LW:   return 6'h23;  C_SW:   return 6'h2b;
      C_ADDI: return 6'h08;  C_ORI:  return 6'h0d;
      C_ANDI: return 6'h0c;  C_LUI:  return 6'h0f;
      C_POUT: return 6'h1e;  C_PIN:  return 6'h1f;
      C_BEQ:  return 6'h04;  C_BNE:  return 6'h05;
      C_J:    return 6'h02;  C_JAL:  return 6'h03;
      default: return 6'h3f;
    endcase
  endfunction

  function automatic outs_t b_reset();
    outs_t e = '0; e.mem_read = 1'b1; return e;
  endfunction
  function automatic outs_t b_fetch(logic rdy);
    outs_t e = '0;
    e.mem_read = 1'b1; e.alu_src_b = 2'd1; e.alu_op = 6'd4;
    e.ir_write = rdy; e.pc_write = rdy; e.state = 3'd0; return e;
  endfunction
  function automatic outs_t b_decode();
    outs_t e = '0; e.alu_src_b = 2'd3; e.alu_op = 6'd4; e.state = 3'd1; return e;
  endfunction
  function automatic outs_t b_exec(cls_t c);
    outs_t e = '0;
    e.state = 3'd2; e.alu_src_a = 1'b1;
    if (c == C_R) begin
      e.alu_src_b = 2'd0; e.alu_op = 6'd32;
    end else begin
      e.alu_src_b = 2'd2;
      e.alu_op = (c == C_ORI) ? 6'd16 : (c == C_ANDI) ? 6'd8 : (c == C_LUI) ? 6'd2 : 6'd4;
    end
    e.io_write = (c == C_POUT);
    return e;
  endfunction
  function automatic outs_t b_mem(cls_t c);
    outs_t e = '0;
    e.state = 3'd3; e.i_or_d = 1'b1;
    e.mem_read = (c == C_LW); e.mem_write = (c == C_SW); return e;
  endfunction
  function automatic outs_t b_wb(cls_t c);
    outs_t e = '0;
    e.state = 3'd4; e.reg_write = 1'b1; e.reg_dst = (c == C_R);
    e.mem_to_reg = (c == C_LW); e.pin_en = (c == C_PIN); return e;
  endfunction
  function automatic outs_t b_branch(cls_t c, logic z);
    outs_t e = '0;
    e.state = 3'd5; e.alu_src_a = 1'b1; e.alu_op = 6'd1; e.pc_src = 2'd3;
    e.pc_write = (c == C_BEQ) ? z : !z; return e;
  endfunction
  function automatic outs_t b_jump(cls_t c);
    outs_t e = '0;
    e.state = 3'd6; e.pc_write = 1'b1; e.pc_src = (c == C_JR) ? 2'd1 : 2'd2;
    e.jal = (c == C_JAL); e.reg_write = (c == C_JAL); return e;
  endfunction
  function automatic outs_t b_trap();
    outs_t e = '0; e.trap = 1'b1; e.state = 3'd7; return e;
  endfunction

  function automatic logic rnd_bit();
    return logic'($urandom_range(0, 1));
  endfunction

  // One clock cycle: apply inputs, publish expectation, advance past the edge.
  task automatic step(input logic rst, input logic rdy, input logic z, input outs_t e);
    reset = rst; mem_ready = rdy; zero = z; exp_b = e; exp_valid = 1'b1;
    @(posedge clk);
`ifdef MIPS_CTRL_PERF_CNT_EN
    if (rst) begin
      m_instr = 0; m_stall = 0;
    end else begin
      if ((e.state == 3'd0 || e.state == 3'd3) && !rdy) m_stall++;
      if (e.state == 3'd0 && rdy) m_instr++;
    end
`endif
    #1;
  endtask

  task automatic run_instr(input cls_t c, input logic [5:0] op, input logic [5:0] fn,
                           input int fw, input int mw, input logic z);
    opcode = op; funct = fn;
    for (int i = 0; i < fw; i++) step(1'b0, 1'b0, z, b_fetch(1'b0));
    step(1'b0, 1'b1, z, b_fetch(1'b1));
    step(1'b0, rnd_bit(), z, b_decode());
    if (c == C_ILL) begin
      step(1'b0, rnd_bit(), z, b_trap());
    end else if (c == C_BEQ || c == C_BNE) begin
      step(1'b0, rnd_bit(), z, b_branch(c, z));
    end else if (c == C_J || c == C_JAL || c == C_JR) begin
      step(1'b0, rnd_bit(), z, b_jump(c));
    end else begin
      if (c != C_PIN) step(1'b0, rnd_bit(), z, b_exec(c));
      if (c == C_LW || c == C_SW) begin
        for (int i = 0; i < mw; i++) step(1'b0, 1'b0, z, b_mem(c));
        step(1'b0, 1'b1, z, b_mem(c));
      end
      if (c != C_SW && c != C_POUT) step(1'b0, rnd_bit(), z, b_wb(c));
    end
  endtask

  task automatic pin(input string nm, input logic [31:0] g, input logic [31:0] e);
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, g, e);
    end
  endtask

  function automatic logic [31:0] st_seq();
    logic [31:0] s = '0;
    foreach (obs_q[i]) s = (s << 3) | 32'(obs_q[i].state);
    return s;
  endfunction

  // Single compare process: every cycle with a published expectation.
  always @(negedge clk) begin
    if (exp_valid) begin
      cyc++;
      checks++;
      if (got !== exp_b) begin
        failures++;
        $display("FAIL cyc=%0d outputs got=%h exp=%h (state got=%0d exp=%0d)",
                 cyc, got, exp_b, got.state, exp_b.state);
      end
      obs_q.push_back(got);
`ifdef MIPS_CTRL_PERF_CNT_EN
      checks++;
      if (instr_count !== m_instr || stall_count !== m_stall) begin
        failures++;
        $display("FAIL cyc=%0d perf got=%0d/%0d exp=%0d/%0d",
                 cyc, instr_count, stall_count, m_instr, m_stall);
      end
`endif
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ill_ops [9];
    ill_ops = '{6'h01, 6'h06, 6'h07, 6'h09, 6'h0a, 6'h0b, 6'h10, 6'h20, 6'h3f};
    @(posedge clk); #1;
    step(1'b1, 1'b0, 1'b0, b_reset());
    step(1'b1, 1'b1, 1'b0, b_reset());

    // 1. ADD, zero waits
    obs_q.delete();
    run_instr(C_R, 6'h00, 6'h20, 0, 0, 1'b0);
    pin("add_states", st_seq(), 32'o0124);
    pin("add_exec_aluop", 32'(obs_q[2].alu_op), 32'd32);
    pin("add_exec_regwrite", 32'(obs_q[2].reg_write), 32'd0);
    pin("add_wb_regdst", 32'({obs_q[3].reg_write, obs_q[3].reg_dst}), 32'd3);
`ifdef MIPS_CTRL_PERF_CNT_EN
    pin("perf_instr_one", instr_count, 32'd1);
`endif

    // 2. LW with two MEM wait cycles
    obs_q.delete();
    run_instr(C_LW, 6'h23, 6'h00, 0, 2, 1'b0);
    pin("lw_states", st_seq(), 32'o0123334);
    pin("lw_mem_req", 32'({obs_q[3].mem_read, obs_q[4].mem_read, obs_q[5].i_or_d}), 32'd7);
    pin("lw_wb_memtoreg", 32'(obs_q[6].mem_to_reg), 32'd1);

    // 3. branches with zero=0
    obs_q.delete();
    run_instr(C_BEQ, 6'h04, 6'h00, 0, 0, 1'b0);
    pin("beq_nottaken", 32'(obs_q[2].pc_write), 32'd0);
    obs_q.delete();
    run_instr(C_BNE, 6'h05, 6'h00, 0, 0, 1'b0);
    pin("bne_taken", 32'({obs_q[2].pc_write, obs_q[2].pc_src}), 32'd7);

    // 4. JAL and JR
    obs_q.delete();
    run_instr(C_JAL, 6'h03, 6'h00, 0, 0, 1'b0);
    pin("jal_jump", 32'({obs_q[2].pc_write, obs_q[2].pc_src, obs_q[2].jal, obs_q[2].reg_write}), 32'b11011);
    obs_q.delete();
    run_instr(C_JR, 6'h00, 6'h08, 0, 0, 1'b0);
    pin("jr_jump", 32'({obs_q[2].pc_src, obs_q[2].reg_write}), 32'b010);

    // 5a. FETCH timeout
    obs_q.delete();
    opcode = 6'h08;
    for (int i = 0; i < MEM_TIMEOUT; i++) step(1'b0, 1'b0, 1'b0, b_fetch(1'b0));
    step(1'b0, 1'b1, 1'b0, b_trap());
    step(1'b0, 1'b1, 1'b0, b_trap());
    pin("to_last_fetch", 32'(obs_q[14].state), 32'd0);
    pin("to_trap_cycle16", 32'({obs_q[15].state, obs_q[15].trap}), 32'hf);
    pin("to_trap_sticky", 32'(obs_q[16].trap), 32'd1);
    step(1'b1, 1'b0, 1'b0, b_reset());

    // 5b. illegal opcode 3f, then recovery
    obs_q.delete();
    run_instr(C_ILL, 6'h3f, 6'h00, 0, 0, 1'b0);
    pin("ill_trap", 32'({obs_q[2].state, obs_q[2].trap}), 32'hf);
    step(1'b1, 1'b1, 1'b0, b_reset());
    obs_q.delete();
    run_instr(C_ADDI, 6'h08, 6'h00, 0, 0, 1'b0);
    pin("recover_fetch", 32'({obs_q[0].state, obs_q[0].trap}), 32'd0);

    // 5c. MEM timeout on a load
    opcode = 6'h23;
    step(1'b0, 1'b1, 1'b0, b_fetch(1'b1));
    step(1'b0, 1'b0, 1'b0, b_decode());
    step(1'b0, 1'b0, 1'b0, b_exec(C_LW));
    for (int i = 0; i < MEM_TIMEOUT; i++) step(1'b0, 1'b0, 1'b0, b_mem(C_LW));
    step(1'b0, 1'b1, 1'b0, b_trap());
    step(1'b1, 1'b0, 1'b0, b_reset());

    // 6. reset during SW wait; counter must restart so 14 more waits do not trap
    obs_q.delete();
    opcode = 6'h2b;
    step(1'b0, 1'b1, 1'b0, b_fetch(1'b1));
    step(1'b0, 1'b0, 1'b0, b_decode());
    step(1'b0, 1'b0, 1'b0, b_exec(C_SW));
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, b_mem(C_SW));
    step(1'b1, 1'b0, 1'b0, b_reset());
`ifdef MIPS_CTRL_PERF_CNT_EN
    pin("perf_instr_reset", instr_count, 32'd0);
`endif
    run_instr(C_ADDI, 6'h08, 6'h00, MEM_TIMEOUT - 1, 0, 1'b0);
    pin("sw_reset_nowrite", 32'(obs_q[13].mem_write), 32'd0);
    pin("sw_reset_fetch", 32'(obs_q[14].state), 32'd0);

    // Random instruction stream
    for (int n = 0; n < 80; n++) begin
      cls_t       c;
      logic [5:0] op, fn;
      c  = cls_t'($urandom_range(0, int'(C_N) - 1));
      op = (c == C_ILL) ? ill_ops[$urandom_range(0, 8)] : op_of(c);
      fn = 6'($urandom_range(0, 63));
      if (c == C_JR) fn = 6'h08;
      if (c == C_R && fn == 6'h08) fn = 6'h20;
      run_instr(c, op, fn, $urandom_range(0, 3), $urandom_range(0, 4), rnd_bit());
      if (c == C_ILL) step(1'b1, rnd_bit(), 1'b0, b_reset());
    end

    exp_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
